fetch_unit: RTL and testbench

//   Instruction fetch stage. Owns the program counter, drives the instruction ROM address,

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the program counter, addresses an
//   asynchronous-read instruction ROM and captures each returned word with its
//   PC into a small FIFO. Decode takes the FIFO head over a valid/ready
//   handshake. Branch redirects flush the FIFO and reload the PC. Halt stops new
//   fetches but lets the FIFO drain.
//
// Parameters
//   DEPTH      fetch queue entries (power of two, >= 2)
//   RESET_VEC  PC after reset (bit 0 forced to 0)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   rom_addr   ROM address (always the PC register)
//   rom_data   ROM word for rom_addr, same cycle
//   br_valid   redirect request (single-cycle pulse)
//   br_target  redirect PC (bit 0 forced to 0)
//   halt       level; while high no new fetches are issued
//   if_valid   queue head valid
//   if_instr   queue head instruction (0 when not valid)
//   if_pc      queue head PC (0 when not valid)
//   id_ready   decode accepts the head this cycle
//   fetching   high while the fetch FSM is in RUN
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  input  logic        halt,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  output logic        fetching
);

  localparam int          AW     = $clog2(DEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [15:0] PC_RST = RESET_VEC & 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     pc_reg, pc_next;
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;

  logic            pop;
  logic            push;
  logic            redirect;

  logic [15:0]     ent_pc    [DEPTH];
  logic [15:0]     ent_instr [DEPTH];

  // Redirects are only honoured once the FSM has left IDLE.
  assign redirect = br_valid && (state_reg != IDLE);
  assign pop      = if_valid && id_ready;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign push     = (state_reg == RUN) && !halt && !br_valid &&
                    ((count_reg < CW'(DEPTH)) || pop);

  assign rom_addr = pc_reg;
  assign fetching = (state_reg == RUN);
  assign if_valid = (count_reg != '0);
  assign if_pc    = if_valid ? ent_pc[head_reg]    : 16'h0000;
  assign if_instr = if_valid ? ent_instr[head_reg] : 16'h0000;

  // Queue storage: one register pair per entry, written at the tail on push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    logic [15:0] pc_reg_e;
    logic [15:0] instr_reg_e;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_reg_e    <= 16'h0000;
        instr_reg_e <= 16'h0000;
      end else if (push && (tail_reg == AW'(gi))) begin
        pc_reg_e    <= pc_reg;
        instr_reg_e <= rom_data;
      end
    end

    assign ent_pc[gi]    = pc_reg_e;
    assign ent_instr[gi] = instr_reg_e;
  end

  // Next-state logic for the FSM, PC and queue bookkeeping.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;

    case (state_reg)
      IDLE:    state_next = RUN;
      RUN:     if (halt && !br_valid) state_next = HALTED;
      HALTED:  if (!halt || br_valid) state_next = RUN;
      default: state_next = IDLE;
    endcase

    if (redirect) begin
      // Flush wins over everything; a concurrent pop is simply absorbed.
      pc_next    = br_target & 16'hFFFE;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        pc_next   = pc_reg + 16'd2;
        tail_next = tail_reg + 1'b1;
      end
      if (pop) begin
        head_next = head_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= PC_RST;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed, table-driven bench for fetch_unit. Each table row gives the
//   inputs held for one clock and the outputs expected just after that edge.
//   A second instance with RESET_VEC=0xFFFC shares the stimulus to cover the
//   PC wrap after reset. Hand-written sequences cover async reset mid-stream
//   and a redirect issued while still in IDLE.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic [15:0] br_target;
  logic        halt;
  logic        id_ready;

  logic [15:0] rom_addr, rom_data;
  logic        if_valid, fetching;
  logic [15:0] if_instr, if_pc;

  logic [15:0] rom_addr2, rom_data2;
  logic        if_valid2, fetching2;
  logic [15:0] if_instr2, if_pc2;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  assign rom_data  = rom_word(rom_addr);
  assign rom_data2 = rom_word(rom_addr2);

  fetch_unit #(.DEPTH(2), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .br_valid(br_valid), .br_target(br_target), .halt(halt),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .fetching(fetching)
  );

  fetch_unit #(.DEPTH(2), .RESET_VEC(16'hFFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .br_valid(br_valid), .br_target(br_target), .halt(halt),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .id_ready(id_ready), .fetching(fetching2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [15:0] tgt;
    logic        hlt;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_rom;
    logic        e_fetch;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic br, input logic [15:0] tgt,
                              input logic hlt, input logic rdy,
                              input logic ev, input logic [15:0] epc,
                              input logic [15:0] erom, input logic ef);
    vec_t v;
    v.br = br; v.tgt = tgt; v.hlt = hlt; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_rom = erom; v.e_fetch = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic ev, input logic [15:0] epc,
                            input logic [15:0] erom, input logic ef);
    logic [15:0] ei;
    ei = ev ? rom_word(epc) : 16'h0000;
    check({tag, " if_valid"}, 32'(if_valid), 32'(ev));
    check({tag, " if_pc"},    32'(if_pc),    32'(ev ? epc : 16'h0000));
    check({tag, " if_instr"}, 32'(if_instr), 32'(ei));
    check({tag, " rom_addr"}, 32'(rom_addr), 32'(erom));
    check({tag, " fetching"}, 32'(fetching), 32'(ef));
    $display("%s: valid=%0d pc=%h instr=%h rom_addr=%h fetching=%0d",
             tag, if_valid, if_pc, if_instr, rom_addr, fetching);
  endtask

  // Drive inputs now, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input logic br, input logic [15:0] tgt, input logic hlt, input logic rdy);
    br_valid  = br;
    br_target = tgt;
    halt      = hlt;
    id_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wrap_pc [4];

  initial begin
    // i -> state after that edge
    tbl[0]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 1); // IDLE -> RUN
    tbl[1]  = mk(0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0002, 1); // first word
    tbl[2]  = mk(0, 16'h0000, 0, 1, 1, 16'h0002, 16'h0004, 1);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 1, 16'h0004, 16'h0006, 1);
    tbl[4]  = mk(0, 16'h0000, 0, 1, 1, 16'h0006, 16'h0008, 1);
    tbl[5]  = mk(0, 16'h0000, 0, 0, 1, 16'h0006, 16'h000A, 1); // stall, fills
    tbl[6]  = mk(0, 16'h0000, 0, 0, 1, 16'h0006, 16'h000A, 1); // full, frozen
    tbl[7]  = mk(0, 16'h0000, 0, 0, 1, 16'h0006, 16'h000A, 1);
    tbl[8]  = mk(0, 16'h0000, 0, 1, 1, 16'h0008, 16'h000C, 1); // full + pop + push
    tbl[9]  = mk(0, 16'h0000, 0, 1, 1, 16'h000A, 16'h000E, 1);
    tbl[10] = mk(1, 16'h0013, 0, 0, 0, 16'h0000, 16'h0012, 1); // redirect on full queue
    tbl[11] = mk(0, 16'h0000, 0, 0, 1, 16'h0012, 16'h0014, 1);
    tbl[12] = mk(0, 16'h0000, 0, 0, 1, 16'h0012, 16'h0016, 1);
    tbl[13] = mk(0, 16'h0000, 1, 1, 1, 16'h0014, 16'h0016, 0); // halt: drain
    tbl[14] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0016, 0);
    tbl[15] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0016, 0);
    tbl[16] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0016, 0);
    tbl[17] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0016, 1); // HALTED -> RUN
    tbl[18] = mk(0, 16'h0000, 0, 1, 1, 16'h0016, 16'h0018, 1); // resume at frozen pc
    tbl[19] = mk(0, 16'h0000, 0, 1, 1, 16'h0018, 16'h001A, 1);
    tbl[20] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'h001A, 0);
    tbl[21] = mk(1, 16'h0100, 1, 1, 0, 16'h0000, 16'h0100, 1); // redirect wakes HALTED
    tbl[22] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0100, 0);
    tbl[23] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0100, 1);
    tbl[24] = mk(0, 16'h0000, 0, 1, 1, 16'h0100, 16'h0102, 1);
    tbl[25] = mk(1, 16'hFFFD, 0, 1, 0, 16'h0000, 16'hFFFC, 1); // redirect with pop
    tbl[26] = mk(0, 16'h0000, 0, 1, 1, 16'hFFFC, 16'hFFFE, 1);
    tbl[27] = mk(0, 16'h0000, 0, 1, 1, 16'hFFFE, 16'h0000, 1); // pc wraps
    tbl[28] = mk(0, 16'h0000, 0, 1, 1, 16'h0000, 16'h0002, 1);

    wrap_pc[0] = 16'hFFFC; wrap_pc[1] = 16'hFFFE;
    wrap_pc[2] = 16'h0000; wrap_pc[3] = 16'h0002;

    rst_n = 1'b0; br_valid = 1'b0; br_target = 16'h0000; halt = 1'b0; id_ready = 1'b1;
    #12;
    check_head("reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("reset rom_addr vec", 32'(rom_addr2), 32'(16'hFFFC));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].br, tbl[i].tgt, tbl[i].hlt, tbl[i].rdy);
      check_head($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_rom, tbl[i].e_fetch);
      if (i >= 1 && i <= 4) begin
        check($sformatf("vec%0d wrap if_pc", i), 32'(if_pc2), 32'(wrap_pc[i-1]));
        check($sformatf("vec%0d wrap if_valid", i), 32'(if_valid2), 32'(1'b1));
      end
    end

    // Asynchronous reset in the middle of a cycle.
    br_valid = 1'b0; halt = 1'b0; id_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_head("async reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("async reset rom_addr vec", 32'(rom_addr2), 32'(16'hFFFC));

    // Restart; a redirect during IDLE must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0040, 1'b0, 1'b1);
    check_head("idle br ignored", 1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check_head("restart 0", 1'b1, 16'h0000, 16'h0002, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check_head("restart 1", 1'b1, 16'h0002, 16'h0004, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
